popcount_seq: RTL and testbench
===============================

POPCOUNT_SEQ -- requirements
Module: popcount_seq

Interface
REQ-001 Parameter WIDTH, default 24, input word width; SHALL be a multiple of 3 and at least 3.
REQ-002 Derived constant NSLICE = WIDTH/3 (slices per word); CW = $clog2(WIDTH+1) (result width).
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data holds a word to count.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 in_data  input  WIDTH  word to popcount.
REQ-008 abort  input  1  discard current job.
REQ-009 out_valid  output  1  out_count holds a finished result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_count  output  CW  number of 1 bits in the accepted word.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE); busy SHALL equal (state!=IDLE).
REQ-015 IDLE with in_valid=1: on that edge, load in_data into shift register, clear accumulator, clear slice index, go RUN.
REQ-016 RUN, each cycle: present low 3 bits of shift register to the shared 3-input counter; on the edge, add its 2-bit count to accumulator, shift register right by 3, increment index.
REQ-017 RUN with index==NSLICE-1: on that edge, add the final slice and go DONE.
REQ-018 Latency: out_valid SHALL rise exactly NSLICE cycles after the accepting edge.
REQ-019 Accumulator SHALL be CW bits, zero-extended adds, never overflow (max WIDTH).
REQ-020 DONE: out_count SHALL hold stable until the edge with out_ready=1, then go IDLE; a new word SHALL NOT be accepted in the same cycle.
REQ-021 abort=1 in RUN or DONE: next edge go IDLE, discard result, no out_valid pulse; abort has priority over completion and over out_ready.
REQ-022 abort in IDLE SHALL be ignored, and SHALL block acceptance that cycle (in_ready stays high; no load).
REQ-023 out_count SHALL be 0 whenever state!=DONE.
REQ-024 in_data changes while not in IDLE SHALL have no effect.

Reset
REQ-025 reset=1 on an edge: state IDLE, accumulator 0, index 0, shift register 0; overrides all other inputs including mid-RUN and DONE.
REQ-026 After reset: in_ready=1, out_valid=0, busy=0, out_count=0.

Structure
REQ-027 Package popcount_pkg SHALL hold state enum type, SLICE_W=3 constant, and a function computing CW from WIDTH.
REQ-028 The 3-input ones counter SHALL be one instance of the existing count_ones sub-module (a,b,c -> 2-bit count), time-shared across slices; no other arithmetic instances.
REQ-029 Single always_ff for state/datapath plus combinational output logic; no latches, no multicycle paths.

Verification (WIDTH=24, NSLICE=8)
REQ-030 in_data=24'h000000 accepted -> out_valid high 8 cycles later, out_count=0.
REQ-031 in_data=24'hFFFFFF -> out_count=24 after 8 cycles; 24'hA5A5A5 -> out_count=12.
REQ-032 Result ready, out_ready held 0 for 5 cycles -> out_valid and out_count=12 stable all 5 cycles; in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-033 abort pulsed at RUN cycle 4 -> IDLE next edge, out_valid never asserted, next word 24'h000007 -> out_count=3.
REQ-034 reset pulsed mid-RUN and again in DONE -> outputs at reset values next cycle; following word 24'h800001 -> out_count=2.
REQ-035 Back-to-back words with out_ready tied 1 -> one accept every 10 cycles (accept, 8 RUN, 1 DONE); results in order; assertions check out_count equals $countones of accepted word.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared types and constants for the sequential popcount block.
// The word is counted one 3-bit slice at a time, so the slice width lives here.
package popcount_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 3;

    // Result width that can hold a count of 0..width.
    function automatic int cw_of(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/count_ones.sv
// Three-input ones counter (a full adder): count = a + b + c.
// Purely combinational, no latency, no flow control.
module count_ones (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [1:0] count
);

    assign count[0] = a ^ b ^ c;
    assign count[1] = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/popcount_seq.sv
// Sequential popcount: one 3-bit slice per cycle through a single shared counter.
// Result valid NSLICE cycles after accept; holds until out_ready; one word in flight.
module popcount_seq
    import popcount_pkg::*;
#(
    parameter  int WIDTH  = 24,
    localparam int NSLICE = WIDTH / SLICE_W,
    localparam int CW     = cw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             busy
);

    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    acc;
    logic [IW-1:0]    idx;
    logic [1:0]       slice_cnt;
    logic             last_slice;

    count_ones u_count_ones (
        .a     (sr[0]),
        .b     (sr[1]),
        .c     (sr[2]),
        .count (slice_cnt)
    );

    assign last_slice = (idx == IW'(NSLICE - 1));

    // Abort wins over both completion and out_ready; in IDLE it only blocks acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid && !abort)  state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort)           state_nxt = ST_IDLE;
                else if (last_slice) state_nxt = ST_DONE;
            end
            ST_DONE: if (abort || out_ready) state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            sr    <= '0;
            acc   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_RUN) begin
                sr  <= in_data;
                acc <= '0;
                idx <= '0;
            end else if (state == ST_RUN && !abort) begin
                acc <= acc + CW'(slice_cnt);
                sr  <= sr >> SLICE_W;
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        out_count = (state == ST_DONE) ? acc : '0;
    end

endmodule

// File: tb/tb_popcount_seq.sv
// Directed bench for popcount_seq at WIDTH=24: latency, hold, abort, reset and streaming.
module tb_popcount_seq;

    localparam int WIDTH = 24;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             busy;

    int total = 0;
    int bad   = 0;

    popcount_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [WIDTH-1:0] data);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        chk("accept_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = data;
        tick();
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic run_word(input string tag, input logic [WIDTH-1:0] data, input int exp);
        int n;
        accept(data);
        chk({tag, "_run_cnt0"}, int'(out_count), 0);
        wait_out(n);
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_cnt"}, int'(out_count), exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, int'(in_ready), 1);
    endtask

    logic [WIDTH-1:0] b2b_vec [4] = '{24'h0F0F0F, 24'h000001, 24'hFFF000, 24'h111111};
    int               b2b_exp [4] = '{12, 1, 12, 6};

    initial begin
        int n;
        int seen;
        int k;
        int last;
        int nres;
        int idx_q[$];
        int widx;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_count", int'(out_count), 0);

        run_word("zero", 24'h000000, 0);
        run_word("ones", 24'hFFFFFF, 24);
        run_word("a5", 24'hA5A5A5, 12);
        run_word("mix", 24'h123456, 9);

        // Result held against a stalled consumer; no acceptance on the release edge.
        accept(24'hA5A5A5);
        wait_out(n);
        chk("hold_lat", n, 8);
        in_valid = 1'b1;
        in_data  = 24'hFFFFFF;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_cnt", int'(out_count), 12);
            chk("hold_in_ready", int'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("release_valid", int'(out_valid), 0);
        chk("release_busy", int'(busy), 0);
        chk("release_cnt", int'(out_count), 0);

        // Abort in IDLE blocks the load.
        in_valid = 1'b1;
        abort    = 1'b1;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        chk("idle_abort_busy", int'(busy), 0);
        chk("idle_abort_ready", int'(in_ready), 1);

        // Abort mid-RUN: back to IDLE, no result ever shows.
        accept(24'hFFFFFF);
        repeat (3) tick();
        chk("abort_pre_busy", int'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("abort_no_valid", seen, 0);
        run_word("after_abort", 24'h000007, 3);

        // Abort in DONE outranks out_ready.
        accept(24'h00000F);
        wait_out(n);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("done_abort_valid", int'(out_valid), 0);
        chk("done_abort_busy", int'(busy), 0);

        // Reset mid-RUN and again in DONE.
        accept(24'hFFFFFF);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rrun_in_ready", int'(in_ready), 1);
        chk("rrun_busy", int'(busy), 0);
        chk("rrun_out_valid", int'(out_valid), 0);
        accept(24'hFFFFFF);
        wait_out(n);
        chk("rdone_pre_valid", int'(out_valid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rdone_out_valid", int'(out_valid), 0);
        chk("rdone_out_count", int'(out_count), 0);
        chk("rdone_busy", int'(busy), 0);
        run_word("after_reset", 24'h800001, 2);

        // Streaming with the consumer always ready: one accept per 10 cycles.
        out_ready = 1'b1;
        k    = 0;
        last = -1;
        nres = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (out_valid) begin
                if (idx_q.size() > 0) begin
                    widx = idx_q.pop_front();
                    chk("b2b_cnt", int'(out_count), b2b_exp[widx]);
                    chk("b2b_pop", int'(out_count), $countones(b2b_vec[widx]));
                end else begin
                    chk("b2b_spurious", 1, 0);
                end
                nres++;
            end
            if (in_ready && k < 4) begin
                in_valid = 1'b1;
                in_data  = b2b_vec[k];
                idx_q.push_back(k);
                if (last >= 0) chk("b2b_interval", cyc - last, 10);
                last = cyc;
                k++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end else begin
                in_data = WIDTH'($urandom);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_results", nres, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
